red_pitaya_dac_ramp: RTL and testbench
======================================

Name: red_pitaya_dac_ramp

Overview:
Output stage placed directly downstream of each ASG channel's 14-bit signed sample stream, upstream of the DAC data pins. On an output-enable change, it applies a soft-start/soft-stop gain ramp so the analog output never steps abruptly. It then converts the two's-complement result to the DAC's offset-binary format. There is one instance per DAC channel, clocked by the DAC clock.

Parameters:
GW, 16, gain register width; gain value g represents g/2^GW (unity is handled as bypass)

Ports:
dac_clk_i  in  1  DAC clock
dac_rstn_i  in  1  reset, asynchronous, active-low
dat_i  in  14  signed two's-complement sample from the ASG channel
out_en_i  in  1  output enable; level-sensitive, sampled every clock
ramp_step_i  in  GW  gain increment/decrement per clock (unsigned)
dac_dat_o  out  14  offset-binary DAC code
state_o  out  2  current FSM state: 0=OFF, 1=RAMP_UP, 2=ON, 3=RAMP_DOWN
busy_o  out  1  high while in RAMP_UP or RAMP_DOWN
ramp_done_o  out  1  one-cycle pulse on entering ON or OFF from a ramp state, or on a step=0 jump

Behaviour:
- Clock and reset: single clock, dac_clk_i. dac_rstn_i is asynchronous and active-low.
- Reset values (asserted immediately, no clock needed):
  - state OFF, gain 0, all pipeline registers 0
  - dac_dat_o = 14'h2000 (midscale), busy_o = 0, ramp_done_o = 0, state_o = 0
- Reset mid-ramp aborts to OFF with no ramp_done_o pulse.
- OFF:
  - gain = 0; the output sample is forced to signed 0.
  - out_en_i = 1 → RAMP_UP next edge (gain starts from 0).
- RAMP_UP, each clock:
  - if out_en_i = 0 → RAMP_DOWN (gain held this cycle).
  - else if gain + ramp_step_i > 2^GW − 1 (compute in GW+1 bits) → ON, gain = 2^GW − 1, ramp_done_o = 1.
  - else gain += ramp_step_i.
- ON:
  - multiplier bypassed; output = dat_i (delayed to keep latency).
  - out_en_i = 0 → RAMP_DOWN with gain = 2^GW − 1.
- RAMP_DOWN, each clock:
  - if out_en_i = 1 → RAMP_UP (gain held this cycle).
  - else if gain ≤ ramp_step_i → OFF, gain = 0, ramp_done_o = 1.
  - else gain −= ramp_step_i.
- ramp_step_i = 0 (no ramp): from OFF with en=1 go straight to ON; from ON with en=0 go straight to OFF. ramp_done_o pulses on that edge. If step becomes 0 mid-ramp, the transition completes on the next edge the same way, so the FSM never stalls.
- Arithmetic in ramp states:
  - prod = $signed(dat_i) * $signed({1'b0,gain}), 14+GW+1 bits.
  - scaled = prod[GW+13:GW], i.e. arithmetic shift right by GW, truncation toward −inf.
  - |scaled| ≤ |dat_i|, so no saturation logic is needed.
- Latency: fixed 2 clocks from dat_i to dac_dat_o in every state.
  - Stage 1: registered multiply, or registered bypass/zero select.
  - Stage 2: format conversion.
  - The gain/state used for a sample are the values registered at the edge that samples dat_i into stage 1.
- Format conversion: dac_dat_o = {~s[13], s[12:0]}, where s is the stage-1 result.
- state_o and busy_o are registered outputs reflecting the current state. ramp_done_o is registered and is high in the first cycle state_o shows the new state.
- ramp_step_i is sampled every clock; it may change mid-ramp and takes effect immediately.

Test Plan:
- Reset: hold dac_rstn_i = 0 with dat_i = 14'h1FFF and out_en_i = 1 → dac_dat_o = 14'h2000, state_o = 0, busy_o = 0. Then release reset mid-cycle and observe that the outputs changed without a clock edge when reset asserted.
- Ramp up: step = 16'h1000, dat_i = 14'h1000 constant, en 0→1.
  - RAMP_UP lasts exactly 16 cycles.
  - Output codes step 0x2000, 0x2100, 0x2200 … 0x2F00, then 0x3000 in ON.
  - ramp_done_o is one pulse, aligned with state_o = 2.
- Scaling, negative data: in RAMP_UP with gain = 16'h8000 and dat_i = 14'h2000 (−8192) → s = −4096 → dac_dat_o = 14'h1000 two clocks later.
- Rounding, negative data: dat_i = −1 with gain = 16'h0001 → s = −1 (floor), dac_dat_o = 14'h1FFF. The same input in OFF → 14'h2000.
- Abort: en 1→0 when gain = 16'h6000 during RAMP_UP, step = 16'h2000.
  - RAMP_DOWN is entered next edge, gain is held that cycle.
  - Gain then goes 0x4000, 0x2000, then OFF on the following edge (gain ≤ step), with ramp_done_o pulsing.
  - Re-raising en mid-down returns to RAMP_UP from the held gain.
- Zero step: step = 0, en 0→1 → ON on the next edge with ramp_done_o = 1, and dat_i = 14'h1FFF appears as 14'h3FFF after 2 clocks. Then en 1→0 → OFF on the next edge, with dac_dat_o = 14'h2000.

Source files
------------

// File: rtl/red_pitaya_dac_ramp.sv
// Per-channel DAC output stage: soft-start/soft-stop gain ramp on output-enable
// changes, followed by two's-complement to offset-binary conversion.
// Fixed 2-clock latency from dat_i to dac_dat_o in every state.
module red_pitaya_dac_ramp #(
   parameter int GW = 16
) (
   input  logic          dac_clk_i,
   input  logic          dac_rstn_i,
   input  logic [13:0]   dat_i,
   input  logic          out_en_i,
   input  logic [GW-1:0] ramp_step_i,
   output logic [13:0]   dac_dat_o,
   output logic [1:0]    state_o,
   output logic          busy_o,
   output logic          ramp_done_o
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_UP   = 2'd1,
      ST_ON   = 2'd2,
      ST_DOWN = 2'd3
   } state_t;

   localparam logic [GW-1:0] GAIN_MAX = '1;

   state_t        state_q, state_d;
   logic [GW-1:0] gain_q, gain_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic [GW:0]   gain_sum;
   logic          step_zero;

   logic signed [14+GW:0] prod;
   logic signed [13:0]    scaled;
   logic signed [13:0]    s1_q, s1_d;
   logic [13:0]           dac_q;
   logic                  unused_prod;

   assign gain_sum  = {1'b0, gain_q} + {1'b0, ramp_step_i};
   assign step_zero = (ramp_step_i == '0);

   // State, gain and status registers; reset aborts any ramp silently.
   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         state_q <= ST_OFF;
         gain_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gain_q  <= gain_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next state and gain; a zero step jumps straight to the end point so the
   // FSM can never stall mid-ramp.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_OFF: begin
            gain_d = '0;
            if (out_en_i) begin
               if (step_zero) begin
                  state_d = ST_ON;
                  gain_d  = GAIN_MAX;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_UP;
               end
            end
         end
         ST_UP: begin
            if (!out_en_i) begin
               state_d = ST_DOWN;
            end else if (step_zero || gain_sum[GW]) begin
               state_d = ST_ON;
               gain_d  = GAIN_MAX;
               done_d  = 1'b1;
            end else begin
               gain_d = gain_sum[GW-1:0];
            end
         end
         ST_ON: begin
            gain_d = GAIN_MAX;
            if (!out_en_i) begin
               if (step_zero) begin
                  state_d = ST_OFF;
                  gain_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_DOWN;
               end
            end
         end
         ST_DOWN: begin
            if (out_en_i) begin
               state_d = ST_UP;
            end else if (step_zero || gain_q <= ramp_step_i) begin
               state_d = ST_OFF;
               gain_d  = '0;
               done_d  = 1'b1;
            end else begin
               gain_d = gain_q - ramp_step_i;
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

   // Busy flag follows the incoming state so it lines up with state_o.
   always_comb begin
      busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
   end

   // Gain multiply uses the gain/state being registered alongside the sample.
   assign prod        = $signed(dat_i) * $signed({1'b0, gain_d});
   assign scaled      = prod[GW+13:GW];
   assign unused_prod = ^{prod[GW-1:0], prod[14+GW]};

   // Stage-1 source select: zero when off, bypass when fully on.
   always_comb begin
      s1_d = scaled;
      case (state_d)
         ST_OFF:  s1_d = '0;
         ST_ON:   s1_d = $signed(dat_i);
         default: s1_d = scaled;
      endcase
   end

   // Two-stage output pipeline: scaled sample, then offset-binary code.
   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         s1_q  <= '0;
         dac_q <= 14'h2000;
      end else begin
         s1_q  <= s1_d;
         dac_q <= {~s1_q[13], s1_q[12:0]};
      end
   end

   assign dac_dat_o   = dac_q;
   assign state_o     = state_q;
   assign busy_o      = busy_q;
   assign ramp_done_o = done_q;

endmodule

// File: tb/tb_red_pitaya_dac_ramp.sv
// Bench for red_pitaya_dac_ramp: directed vectors push expected outputs into a
// queue tagged with the clock count they belong to; a negedge monitor compares.
module tb_red_pitaya_dac_ramp;

   logic        clk = 1'b0;
   logic        rstn;
   logic [13:0] dat;
   logic        en;
   logic [15:0] step;
   logic [13:0] dac;
   logic [1:0]  st;
   logic        busy;
   logic        done;

   int errs   = 0;
   int checks = 0;
   int cyc_cnt = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  st;
      logic        dn;
      logic [13:0] dac;
   } exp_t;

   exp_t q[$];

   red_pitaya_dac_ramp #(.GW(16)) dut (
      .dac_clk_i   (clk),
      .dac_rstn_i  (rstn),
      .dat_i       (dat),
      .out_en_i    (en),
      .ramp_step_i (step),
      .dac_dat_o   (dac),
      .state_o     (st),
      .busy_o      (busy),
      .ramp_done_o (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errs++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc_cnt, act, exp_v);
      end
   endtask

   // Monitor: compare the entry due this cycle; flag any entry that was missed.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         if (q[0].cyc == cyc_cnt) begin
            check("state", int'(st), int'(q[0].st));
            check("busy", int'(busy), int'(q[0].st == 2'd1 || q[0].st == 2'd3));
            check("done", int'(done), int'(q[0].dn));
            check("dac", int'(dac), int'(q[0].dac));
            void'(q.pop_front());
         end else if (q[0].cyc < cyc_cnt) begin
            check("missed", cyc_cnt, q[0].cyc);
            void'(q.pop_front());
         end
      end
   end

   // One clock of stimulus with the outputs expected right after that edge.
   task automatic cyc(input bit e, input logic [13:0] d, input logic [15:0] s,
                      input logic [1:0] est, input bit edn, input logic [13:0] edac);
      exp_t x;
      en = e; dat = d; step = s;
      x.cyc = cyc_cnt + 1; x.st = est; x.dn = edn; x.dac = edac;
      q.push_back(x);
      @(posedge clk); #1;
   endtask

   initial begin
      rstn = 1'b0; en = 1'b1; dat = 14'h1FFF; step = 16'h1000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dac", int'(dac), 'h2000);
      check("rst_state", int'(st), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      en = 1'b0;
      rstn = 1'b1;

      // Ramp up with step 0x1000 on constant 0x1000 data: 16 RAMP_UP cycles.
      cyc(0, 14'h1000, 16'h1000, 2'd0, 0, 14'h2000);
      cyc(1, 14'h1000, 16'h1000, 2'd1, 0, 14'h2000);
      for (int k = 2; k <= 16; k++)
         cyc(1, 14'h1000, 16'h1000, 2'd1, 0, 14'(14'h2000 + (k - 2) * 14'h100));
      cyc(1, 14'h1000, 16'h1000, 2'd2, 1, 14'h2F00);
      cyc(1, 14'h1000, 16'h1000, 2'd2, 0, 14'h3000);

      // Zero step: ON->OFF and OFF->ON jumps with a done pulse each.
      cyc(1, 14'h1FFF, 16'h0000, 2'd2, 0, 14'h3000);
      cyc(0, 14'h1FFF, 16'h0000, 2'd0, 1, 14'h3FFF);
      cyc(0, 14'h1FFF, 16'h0000, 2'd0, 0, 14'h2000);
      cyc(1, 14'h1FFF, 16'h0000, 2'd2, 1, 14'h2000);
      cyc(1, 14'h1FFF, 16'h0000, 2'd2, 0, 14'h3FFF);
      cyc(0, 14'h1FFF, 16'h0000, 2'd0, 1, 14'h3FFF);
      cyc(0, 14'h1FFF, 16'h0000, 2'd0, 0, 14'h2000);

      // Negative scaling at gain 0x8000, floor rounding at gain 1, step->0 mid-ramp.
      cyc(1, 14'h0000, 16'h8000, 2'd1, 0, 14'h2000);
      cyc(1, 14'h2000, 16'h8000, 2'd1, 0, 14'h2000);
      cyc(0, 14'h0000, 16'h8000, 2'd3, 0, 14'h1000);
      cyc(0, 14'h0000, 16'h7FFF, 2'd3, 0, 14'h2000);
      cyc(1, 14'h3FFF, 16'h0001, 2'd1, 0, 14'h2000);
      cyc(1, 14'h0000, 16'h0000, 2'd2, 1, 14'h1FFF);
      cyc(0, 14'h3FFF, 16'h0000, 2'd0, 1, 14'h2000);
      cyc(0, 14'h0000, 16'h0000, 2'd0, 0, 14'h2000);

      // Abort at gain 0x6000 with step 0x2000, ramp down to OFF.
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2000);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2000);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2200);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2400);
      cyc(0, 14'h1000, 16'h2000, 2'd3, 0, 14'h2600);
      cyc(0, 14'h1000, 16'h2000, 2'd3, 0, 14'h2600);
      cyc(0, 14'h1000, 16'h2000, 2'd3, 0, 14'h2400);
      cyc(0, 14'h1000, 16'h2000, 2'd0, 1, 14'h2200);
      cyc(0, 14'h1000, 16'h2000, 2'd0, 0, 14'h2000);

      // Re-raise enable mid ramp-down: resumes from the held gain.
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2000);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2000);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2200);
      cyc(0, 14'h1000, 16'h2000, 2'd3, 0, 14'h2400);
      cyc(0, 14'h1000, 16'h2000, 2'd3, 0, 14'h2400);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2200);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2200);
      cyc(1, 14'h1000, 16'h2000, 2'd1, 0, 14'h2400);
      cyc(1, 14'h1000, 16'hFFFF, 2'd2, 1, 14'h2600);
      cyc(1, 14'h1000, 16'hFFFF, 2'd2, 0, 14'h3000);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #1;
      check("drain", q.size(), 0);

      // Asynchronous reset mid-cycle while ON: outputs return without an edge.
      #2;
      rstn = 1'b0;
      #1;
      check("arst_dac", int'(dac), 'h2000);
      check("arst_state", int'(st), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
